// File: rtl/line_fill_arbiter_if.sv
// Request/fill and Sysbus read signals of the line-fill engine.
// The engine uses the slave modport; clients and the bus model use master.
interface line_fill_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int LINE_BEATS     = 8,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ADDR_WIDTH     = 64
);
  localparam int LINE_BITS = LINE_BEATS * BUS_DATA_WIDTH;
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0]            req_ready;
  logic                            fill_valid;
  logic [PW-1:0]                   fill_port;
  logic [ADDR_WIDTH-1:0]           fill_addr;
  logic [LINE_BITS-1:0]            fill_data;
  logic                            busy;

  logic                            bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0]       bus_req;
  logic [BUS_TAG_WIDTH-1:0]        bus_reqtag;
  logic                            bus_reqack;
  logic                            bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0]       bus_resp;
  logic [BUS_TAG_WIDTH-1:0]        bus_resptag;
  logic                            bus_respack;

  modport slave (
    input  req_valid, req_addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output req_ready, fill_valid, fill_port, fill_addr, fill_data, busy,
           bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport master (
    output req_valid, req_addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  req_ready, fill_valid, fill_port, fill_addr, fill_data, busy,
           bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/line_fill_arbiter.sv
// Round-robin line-fill engine: grants one client, issues an aligned line read,
// gathers LINE_BEATS response beats and returns the line with a one-cycle pulse.
module line_fill_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int LINE_BEATS     = 8,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ADDR_WIDTH     = 64,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG = 13'h1100
) (
  input  logic               clk,
  input  logic               reset,
  line_fill_arbiter_if.slave lf
);
  localparam int LINE_BITS = LINE_BEATS * BUS_DATA_WIDTH;
  localparam int OFS       = $clog2(LINE_BEATS * BUS_DATA_WIDTH / 8);
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW        = $clog2(LINE_BEATS);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = (ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                    state;
  logic [PW-1:0]             ptr, port_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [CW-1:0]             cnt;
  logic [LINE_BITS-1:0]      line, line_nxt;

  logic                      fill_valid_q, busy_q, reqcyc_q;
  logic [PW-1:0]             fill_port_q;
  logic [ADDR_WIDTH-1:0]     fill_addr_q;
  logic [LINE_BITS-1:0]      fill_data_q;
  logic [BUS_DATA_WIDTH-1:0] req_q;
  logic [BUS_TAG_WIDTH-1:0]  reqtag_q;

  logic                      any_req;
  logic [PW-1:0]             gnt, gnt_nxt;
  logic [ADDR_WIDTH-1:0]     gnt_addr;
  int                        j;

  // Scan downwards so the port closest to ptr (cyclically) wins.
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    j       = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (lf.req_valid[j]) begin
        any_req = 1'b1;
        gnt     = PW'(j);
      end
    end
  end

  assign gnt_nxt  = (int'(gnt) == NUM_PORTS - 1) ? '0 : gnt + PW'(1);
  assign gnt_addr = lf.req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH] & ~LOW_MASK;

  always_comb begin
    line_nxt = line;
    line_nxt[cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = lf.bus_resp;
  end

  // Grant is combinational so a client sees acceptance in its request cycle.
  assign lf.req_ready   = (state == IDLE && !reset && any_req) ? (NUM_PORTS'(1) << gnt) : '0;
  assign lf.bus_respack = (state == RESP) && lf.bus_respcyc;
  assign lf.fill_valid  = fill_valid_q;
  assign lf.fill_port   = fill_port_q;
  assign lf.fill_addr   = fill_addr_q;
  assign lf.fill_data   = fill_data_q;
  assign lf.busy        = busy_q;
  assign lf.bus_reqcyc  = reqcyc_q;
  assign lf.bus_req     = req_q;
  assign lf.bus_reqtag  = reqtag_q;

  logic unused_tag;
  assign unused_tag = ^lf.bus_resptag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      port_q       <= '0;
      addr_q       <= '0;
      cnt          <= '0;
      line         <= '0;
      fill_valid_q <= 1'b0;
      fill_port_q  <= '0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      busy_q       <= 1'b0;
      reqcyc_q     <= 1'b0;
      req_q        <= '0;
      reqtag_q     <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          port_q   <= gnt;
          addr_q   <= gnt_addr;
          ptr      <= gnt_nxt;
          reqcyc_q <= 1'b1;
          req_q    <= BUS_DATA_WIDTH'(gnt_addr);
          reqtag_q <= READ_TAG;
          busy_q   <= 1'b1;
          state    <= REQ;
        end
        REQ: if (lf.bus_reqack) begin
          reqcyc_q <= 1'b0;
          req_q    <= '0;
          reqtag_q <= '0;
          cnt      <= '0;
          state    <= RESP;
        end
        RESP: if (lf.bus_respcyc) begin
          line <= line_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(LINE_BEATS - 1)) begin
            fill_valid_q <= 1'b1;
            fill_port_q  <= port_q;
            fill_addr_q  <= addr_q;
            fill_data_q  <= line_nxt;
            state        <= DONE;
          end
        end
        DONE: begin
          fill_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/line_fill_arbiter.md
# line_fill_arbiter

Parametrised line-fill engine that sits between the core's cache clients (instruction cache, data cache, and any later page-walker) and the single Sysbus read interface. It arbitrates round-robin among `NUM_PORTS` requesters and issues one aligned line read on the bus. It collects `LINE_BEATS` response beats into a full line and returns that line to the granted port with a one-cycle valid pulse. It replaces the fixed single-client, fixed-block memory fetch path.

## Interface
- `NUM_PORTS`, 2, number of requesting clients (≥1)
- `LINE_BEATS`, 8, bus beats per line (power of two, ≥2)
- `BUS_DATA_WIDTH`, 64, bus beat width in bits
- `BUS_TAG_WIDTH`, 13, bus tag width
- `ADDR_WIDTH`, 64, request address width
- `READ_TAG`, 13'h1100, tag driven on read requests
- Derived: `LINE_BITS = LINE_BEATS*BUS_DATA_WIDTH`, `OFS = log2(LINE_BEATS*BUS_DATA_WIDTH/8)`, `PW = max(1,log2(NUM_PORTS))`

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_PORTS  per-port fill request
- `req_addr`  in  NUM_PORTS*ADDR_WIDTH  per-port byte address; port i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_ready`  out  NUM_PORTS  one-hot grant; request accepted this cycle
- `fill_valid`  out  1  one-cycle pulse, line delivered
- `fill_port`  out  PW  port index of delivered line
- `fill_addr`  out  ADDR_WIDTH  line-aligned address of delivered line
- `fill_data`  out  LINE_BITS  line; beat k in [k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]
- `busy`  out  1  high in any state other than IDLE
- `bus_reqcyc`, `bus_req[BUS_DATA_WIDTH]`, `bus_reqtag[BUS_TAG_WIDTH]`  out  bus request
- `bus_reqack`  in  1  bus request accepted
- `bus_respcyc`, `bus_resp[BUS_DATA_WIDTH]`, `bus_resptag[BUS_TAG_WIDTH]`  in  bus response beat
- `bus_respack`  out  1  response beat accepted

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If any `req_valid` is high, the grant goes to the first requesting port at or after the priority pointer `ptr`, searching cyclically.
  - `req_ready[g]` is high combinationally in that cycle.
  - The engine latches `{g, req_addr[g] with low OFS bits cleared}` and moves to REQ.
  - `ptr` becomes `(g+1) mod NUM_PORTS`.
- REQ:
  - Drives `bus_reqcyc=1`, `bus_req`=latched aligned address, and `bus_reqtag=READ_TAG`.
  - These values hold stable until `bus_reqack` is sampled high. The FSM then moves to RESP with beat counter = 0.
- RESP:
  - `bus_respack = bus_respcyc`.
  - Each cycle with `bus_respcyc` high stores `bus_resp` into beat slot `cnt`, then increments `cnt`.
  - Cycles with `bus_respcyc` low are gaps: no store, no count.
  - When the beat with `cnt == LINE_BEATS-1` is stored, the FSM moves to DONE.
  - `bus_resptag` is not checked.
- DONE: `fill_valid=1` for exactly one cycle; `fill_port`, `fill_addr` and `fill_data` are valid. The FSM then returns to IDLE.
- `fill_port`, `fill_addr` and `fill_data` hold their last values until the next DONE.
- `req_ready` is 0 in every state except IDLE. A requester keeps `req_valid` asserted until granted.
- Outside RESP, `bus_respack=0` and stray response beats are ignored.
- Reset (asynchronous) forces:
  - the FSM to IDLE;
  - `ptr`, `cnt`, all line storage and latched address/port to 0.
  - A fill in progress is abandoned and no `fill_valid` is produced for it.

## Timing
- Reset values:
  - `req_ready=0`, `fill_valid=0`, `fill_port=0`, `fill_addr=0`, `fill_data=0`, `busy=0`;
  - `bus_reqcyc=0`, `bus_req=0`, `bus_reqtag=0`, `bus_respack=0`.
- Bus request outputs are zero in all states except REQ.
- Minimum latency, grant in cycle 0 with no stalls:
  - REQ with immediate ack in cycle 1;
  - beats in cycles 2..LINE_BEATS+1;
  - `fill_valid` in cycle LINE_BEATS+2.
- Each cycle of `bus_reqack` delay or `bus_respcyc` gap adds one cycle.
- Back-to-back fills: IDLE follows DONE, so the earliest next grant is the cycle after `fill_valid`. Line period is ≥ LINE_BEATS+3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Round-robin guarantees each continuously requesting port is served within NUM_PORTS fills.
- Address wrap: alignment only clears low bits. `ADDR_WIDTH`-bit all-ones aligns to `~((1<<OFS)-1)`; there is no carry.

## Test plan
- Single fill, defaults:
  - Stimulus: port 0 requests 0x8000_0047; ack is immediate; beats are 0x11..0x88.
  - Required: `bus_req`=0x8000_0040 with tag 13'h1100; `fill_valid` at cycle 10 with `fill_port=0`, `fill_addr`=0x8000_0040; `fill_data` beat0=0x11 … beat7=0x88.
- Contention:
  - Stimulus: ports 0 and 1 hold `req_valid` continuously from reset.
  - Required: grants alternate 0,1,0,1; no port is granted twice in a row; `req_ready` is one-hot every IDLE cycle.
- Stalls:
  - Stimulus: `bus_reqack` delayed 3 cycles; one `bus_respcyc` gap after beat 2.
  - Required: bus request stays stable for 4 cycles; `fill_valid` at cycle 14; data is in correct beat order; `bus_respack` is low during the gap.
- Reset mid-fill:
  - Stimulus: assert `reset` after beat 3, then drive the remaining beats.
  - Required: outputs are 0 immediately; no `fill_valid`; stray beats are not acked; the next request completes normally with `ptr=0`.
- Configuration `NUM_PORTS=3`, `LINE_BEATS=4`:
  - Stimulus: all three ports request.
  - Required: grant order 0,1,2,0; `fill_addr` has the low 5 bits cleared; fill latency is 6 cycles.
- Idle response:
  - Stimulus: `bus_respcyc` pulses while in IDLE.
  - Required: `bus_respack=0`, `busy=0`, no state change.
